hack_pc_jump: RTL and testbench

- Hack program counter with built-in jump-condition decode. Drives instruction-memory address each cycle.
- Consumes the ALU status flags (zr, ng) and the A register value (jump target).
- Provides the load/increment selection that the 16-bit mux stage implements, registered as the PC.
- Adds stall support, tight-loop halt detection and a saturating taken-jump counter for bring-up benches.

---
 rtl/hack_pc_jump.sv | 96 +++++++++
 tb/tb_hack_pc_jump.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hack_pc_jump.sv
// Hack program counter with jump-condition decode, stall, self-jump halt
// detection and a saturating taken-jump counter.
module hack_pc_jump #(
    parameter int WIDTH       = 16,
    parameter int CNT_W       = 8,
    parameter int HALT_DETECT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             is_c,
    input  logic [2:0]       jmp,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] pc,
    output logic             taken,
    output logic             halted,
    output logic [CNT_W-1:0] jump_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic HD_EN = (HALT_DETECT != 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cond_s;
    logic             taken_s;

    // Jump decode: j1/j2/j3 select lt/eq/gt; zr=ng=1 is decoded literally.
    always_comb begin
        cond_s  = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));
        taken_s = cond_s & en & (state_q == ST_RUN) & ~reset;
    end

    // Next-state, next-PC and counter selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (en) begin
                    if (taken_s) begin
                        pc_d = a;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            cnt_d = cnt_q;
                        end
                        // A tight unconditional loop onto itself means the program has ended.
                        if (HD_EN && (jmp == 3'b111) && (a == pc_q)) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        pc_d = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc       = pc_q;
    assign taken    = taken_s;
    assign halted   = (state_q == ST_HALT);
    assign jump_cnt = cnt_q;

endmodule

// File: tb/tb_hack_pc_jump.sv
// Bench for hack_pc_jump: two instances (default and CNT_W=2/no halt) share
// stimulus and are compared against a behavioural model, a vector table and hand sequences.
module tb_hack_pc_jump;

    logic        clk = 1'b0;
    logic        reset, en, is_c, zr, ng;
    logic [2:0]  jmp;
    logic [15:0] a;

    logic [15:0] pc0, pc1;
    logic        taken0, taken1, halted0, halted1;
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;

    int n_checks = 0;
    int n_err    = 0;

    int m_pc   [2];
    int m_cnt  [2];
    bit m_halt [2];
    int cnt_max[2] = '{255, 3};
    bit hd_en  [2] = '{1'b1, 1'b0};

    logic got_taken0, got_taken1;

    typedef struct {
        logic        rst, en, is_c;
        logic [2:0]  jmp;
        logic        zr, ng;
        logic [15:0] a;
        logic        exp_taken;
        logic [15:0] exp_pc;
        logic        exp_halted;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[9];

    hack_pc_jump #(.WIDTH(16), .CNT_W(8), .HALT_DETECT(1)) dut0 (
        .clk(clk), .reset(reset), .en(en), .is_c(is_c), .jmp(jmp), .zr(zr), .ng(ng), .a(a),
        .pc(pc0), .taken(taken0), .halted(halted0), .jump_cnt(cnt0)
    );

    hack_pc_jump #(.WIDTH(16), .CNT_W(2), .HALT_DETECT(0)) dut1 (
        .clk(clk), .reset(reset), .en(en), .is_c(is_c), .jmp(jmp), .zr(zr), .ng(ng), .a(a),
        .pc(pc1), .taken(taken1), .halted(halted1), .jump_cnt(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Jump rule: taken if any selected relation (lt, eq, gt) holds for the ALU result.
    function automatic bit model_cond(bit c, bit [2:0] j, bit z, bit n);
        bit lt, eq, gt;
        lt = n;
        eq = z;
        gt = !n && !z;
        return c && ((j[2] && lt) || (j[1] && eq) || (j[0] && gt));
    endfunction

    task automatic step(input bit r, input bit e, input bit c, input bit [2:0] j,
                        input bit z, input bit n, input bit [15:0] av);
        bit exp_t[2];
        reset = r; en = e; is_c = c; jmp = j; zr = z; ng = n; a = av;
        #1;
        for (int d = 0; d < 2; d++)
            exp_t[d] = !r && !m_halt[d] && e && model_cond(c, j, z, n);
        got_taken0 = taken0;
        got_taken1 = taken1;
        chk("taken0", int'(taken0), int'(exp_t[0]));
        chk("taken1", int'(taken1), int'(exp_t[1]));
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_pc[d] = 0; m_cnt[d] = 0; m_halt[d] = 1'b0;
            end else if (m_halt[d] || !e) begin
                // hold
            end else if (exp_t[d]) begin
                if (hd_en[d] && j == 3'b111 && int'(av) == m_pc[d]) m_halt[d] = 1'b1;
                m_pc[d]  = int'(av);
                m_cnt[d] = (m_cnt[d] < cnt_max[d]) ? m_cnt[d] + 1 : cnt_max[d];
            end else begin
                m_pc[d] = (m_pc[d] + 1) % 65536;
            end
        end
        @(posedge clk);
        #1;
        chk("pc0", int'(pc0), m_pc[0]);
        chk("halted0", int'(halted0), int'(m_halt[0]));
        chk("cnt0", int'(cnt0), m_cnt[0]);
        chk("pc1", int'(pc1), m_pc[1]);
        chk("halted1", int'(halted1), int'(m_halt[1]));
        chk("cnt1", int'(cnt1), m_cnt[1]);
    endtask

    initial begin
        bit [7:0] mask [3];
        bit       fz   [3];
        bit       fn   [3];
        int       snap;
        int       base;

        //         rst   en    is_c  jmp     zr    ng    a          taken pc         halt  cnt
        vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 16'h0777, 1'b0, 16'h0001, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0, 8'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b0, 8'd0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0040, 1'b0, 8'd1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 16'h0040, 1'b0, 16'h0041, 1'b0, 8'd1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0099, 1'b0, 16'h0041, 1'b0, 8'd1};

        m_pc = '{0, 0}; m_cnt = '{0, 0}; m_halt = '{1'b0, 1'b0};
        reset = 1'b1; en = 1'b0; is_c = 1'b0; jmp = 3'b000; zr = 1'b0; ng = 1'b0; a = 16'h0000;

        // Reset, sequential fetch, first conditional jump and stall.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].is_c, vecs[i].jmp, vecs[i].zr, vecs[i].ng, vecs[i].a);
            chk($sformatf("tbl%0d_taken", i), int'(got_taken0), int'(vecs[i].exp_taken));
            chk($sformatf("tbl%0d_pc", i), int'(pc0), int'(vecs[i].exp_pc));
            chk($sformatf("tbl%0d_halted", i), int'(halted0), int'(vecs[i].exp_halted));
            chk($sformatf("tbl%0d_cnt", i), int'(cnt0), int'(vecs[i].exp_cnt));
        end

        // Full decode table: flag sets eq-only, lt-only, gt-only.
        mask = '{8'b1100_1100, 8'b1111_0000, 8'b1010_1010};
        fz   = '{1'b1, 1'b0, 1'b0};
        fn   = '{1'b0, 1'b1, 1'b0};
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 8; j++) begin
                step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
                base = int'(pc0);
                step(1'b0, 1'b1, 1'b1, 3'(j), fz[f], fn[f], 16'h1234);
                chk($sformatf("dec_f%0d_j%0d_taken", f, j), int'(got_taken0), int'(mask[f][j]));
                chk($sformatf("dec_f%0d_j%0d_pc", f, j), int'(pc0),
                    mask[f][j] ? 32'h1234 : (base + 1) % 65536);
            end
        end

        // Wrap from 0xFFFF and stall with an always-jump pending.
        step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'hFFFF);
        chk("wrap_load", int'(pc0), 32'hFFFF);
        step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
        chk("wrap_pc", int'(pc0), 0);
        snap = int'(cnt0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h5555);
            chk("stall_pc", int'(pc0), 0);
            chk("stall_cnt", int'(cnt0), snap);
        end

        // Self-jump halt, ignored jumps while halted, release by reset.
        step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0010);
        chk("pre_halt", int'(halted0), 0);
        step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0010);
        chk("halt_set", int'(halted0), 1);
        chk("halt_pc", int'(pc0), 32'h0010);
        snap = int'(cnt0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0020);
            chk("halt_hold_pc", int'(pc0), 32'h0010);
            chk("halt_hold_cnt", int'(cnt0), snap);
            chk("halt_taken", int'(got_taken0), 0);
        end
        step(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0020);
        chk("rst_pc", int'(pc0), 0);
        chk("rst_halted", int'(halted0), 0);
        chk("rst_cnt", int'(cnt0), 0);

        // Saturation of a 2-bit counter and no halting when detection is off.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'(16'h0100 + 2 * i));
            chk($sformatf("sat%0d", i), int'(cnt1), (i < 3) ? i + 1 : 3);
        end
        step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0108);
        chk("nohd_halted", int'(halted1), 0);
        chk("nohd_pc", int'(pc1), 32'h0108);
        chk("nohd_cnt", int'(cnt1), 3);
        chk("hd_halted", int'(halted0), 1);

        // Randomized traffic against the model, including illegal flags and self-jumps.
        for (int i = 0; i < 600; i++) begin
            bit          r, e, c, z, n;
            bit [2:0]    j;
            bit [15:0]   av;
            r  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 4) != 0);
            c  = ($urandom_range(0, 3) != 0);
            j  = 3'($urandom_range(0, 7));
            z  = 1'($urandom_range(0, 1));
            n  = 1'($urandom_range(0, 1));
            av = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 9) == 0) begin
                av = 16'(m_pc[0]);
                j  = 3'b111;
            end
            step(r, e, c, j, z, n, av);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
